// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with per-channel enables and
// a ready/valid configuration port. Divide values change only at period ends.
module clk_div_gen #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] div_tick,
  output logic [NUM_CH-1:0] cfg_pending
);

  localparam int unsigned CH_W = 3;

  logic [CNT_W-1:0]  cnt_q      [NUM_CH];
  logic [CNT_W-1:0]  cur_div_q  [NUM_CH];
  logic [CNT_W-1:0]  pend_div_q [NUM_CH];
  logic [NUM_CH-1:0] run_c;
  logic [NUM_CH-1:0] cfg_hit_c;

  assign run_c = {NUM_CH{active}} & ch_en;

  // Out-of-range channel indices are always ready and simply discarded.
  always_comb begin
    cfg_ready = 1'b1;
    cfg_hit_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready    = ~cfg_pending[i];
        cfg_hit_c[i] = cfg_valid & ~cfg_pending[i];
      end
    end
  end

  // Per-channel counter, divided clock, tick and pending divide value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_clk     <= '0;
      div_tick    <= '0;
      cfg_pending <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i]      <= '0;
        cur_div_q[i]  <= CNT_W'(DEFAULT_DIV);
        pend_div_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        div_tick[i] <= 1'b0;
        if (!run_c[i]) begin
          cnt_q[i]   <= '0;
          div_clk[i] <= 1'b0;
          if (cfg_pending[i]) begin
            cur_div_q[i]   <= pend_div_q[i];
            cfg_pending[i] <= 1'b0;
          end
        end else if (cnt_q[i] == cur_div_q[i]) begin
          cnt_q[i]    <= '0;
          div_clk[i]  <= ~div_clk[i];
          div_tick[i] <= ~div_clk[i];
          // Falling toggle closes a full period: safe point to switch divide.
          if (div_clk[i] && cfg_pending[i]) begin
            cur_div_q[i]   <= pend_div_q[i];
            cfg_pending[i] <= 1'b0;
          end
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
        // Accept only happens when not pending, so it never collides with apply.
        if (cfg_hit_c[i]) begin
          pend_div_q[i]  <= cfg_div;
          cfg_pending[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: arithmetic period model checked every cycle, plus
// hand-computed edge positions for the directed scenarios.
module tb_clk_div_gen;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DEF    = 100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              active = 1'b0;
  logic [NUM_CH-1:0] ch_en = '0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [2:0]        cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic [NUM_CH-1:0] div_clk;
  logic [NUM_CH-1:0] div_tick;
  logic [NUM_CH-1:0] cfg_pending;

  int total = 0;
  int bad   = 0;

  clk_div_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst_n(rst_n), .active(active), .ch_en(ch_en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .div_clk(div_clk), .div_tick(div_tick),
    .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a segment starts at enable or at an apply; after n running edges
  // in a segment of divide d, the clock level is (n / (d+1)) mod 2.
  int unsigned m_n    [NUM_CH];
  int unsigned m_div  [NUM_CH];
  int unsigned m_pdiv [NUM_CH];
  bit          m_pend [NUM_CH];
  bit          m_lvl  [NUM_CH];
  bit          m_tk   [NUM_CH];

  function automatic bit model_ready(input logic [2:0] ch);
    if (int'(ch) >= NUM_CH) return 1'b1;
    return !m_pend[ch];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_n[i] = 0; m_div[i] = DEF; m_pdiv[i] = 0;
      m_pend[i] = 0; m_lvl[i] = 0; m_tk[i] = 0;
    end
  endtask

  task automatic model_step(input logic a, input logic [NUM_CH-1:0] en,
                            input logic v, input logic [2:0] ch, input logic [CNT_W-1:0] d);
    int unsigned p;
    bit acc;
    for (int i = 0; i < NUM_CH; i++) begin
      acc = v && (int'(ch) == i) && !m_pend[i];
      if (!(a && en[i])) begin
        if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 0; end
        m_n[i] = 0; m_lvl[i] = 0; m_tk[i] = 0;
      end else begin
        m_n[i]++;
        p = m_div[i] + 1;
        m_lvl[i] = ((m_n[i] / p) % 2) == 1;
        m_tk[i]  = m_lvl[i] && (m_n[i] % p == 0);
        if ((m_n[i] % (2 * p) == 0) && m_pend[i]) begin
          m_div[i] = m_pdiv[i]; m_pend[i] = 0; m_n[i] = 0;
        end
      end
      if (acc) begin m_pdiv[i] = int'(d); m_pend[i] = 1; end
    end
  endtask

  // Compare process: advance the model on each edge and check #1 later.
  initial begin
    logic [NUM_CH-1:0] e_clk, e_tk, e_pend;
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step(active, ch_en, cfg_valid, cfg_ch, cfg_div);
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
        e_clk[i] = m_lvl[i]; e_tk[i] = m_tk[i]; e_pend[i] = m_pend[i];
      end
      check("div_clk", 32'(div_clk), 32'(e_clk));
      check("div_tick", 32'(div_tick), 32'(e_tk));
      check("cfg_pending", 32'(cfg_pending), 32'(e_pend));
      check("cfg_ready", 32'(cfg_ready), 32'(model_ready(cfg_ch)));
    end
  end

  task automatic steps(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Enable both channels with default divide and pin the first two periods.
  task automatic default_periods(input string tag);
    active = 1'b1; ch_en = 2'b11;
    steps(100); check({tag, "_e100_low"}, 32'(div_clk), 32'h0);
    steps(1);   check({tag, "_e101_high"}, 32'(div_clk), 32'h3);
                check({tag, "_e101_tick"}, 32'(div_tick), 32'h3);
    steps(1);   check({tag, "_e102_tick0"}, 32'(div_tick), 32'h0);
    steps(99);  check({tag, "_e201_high"}, 32'(div_clk), 32'h3);
    steps(1);   check({tag, "_e202_low"}, 32'(div_clk), 32'h0);
    steps(100); check({tag, "_e302_low"}, 32'(div_clk), 32'h0);
    steps(1);   check({tag, "_e303_tick"}, 32'(div_tick), 32'h3);
  endtask

  initial begin
    steps(2);
    check("rst_div_clk", 32'(div_clk), 32'h0);
    check("rst_ready", 32'(cfg_ready), 32'h1);
    rst_n = 1'b1;
    default_periods("dflt");

    // Configure while stopped: ch1 <- 0 then ch0 <- 3, each applied next edge.
    active = 1'b0; cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 16'd0;
    steps(1); check("stop_pend_ch1", 32'(cfg_pending), 32'h2);
    cfg_ch = 3'd0; cfg_div = 16'd3;
    steps(1); check("stop_pend_ch0", 32'(cfg_pending), 32'h1);
    cfg_valid = 1'b0;
    steps(1); check("stop_applied", 32'(cfg_pending), 32'h0);

    active = 1'b1;
    steps(1); check("div0_k1", 32'(div_clk[1]), 32'h1);
    steps(1); check("div0_k2", 32'(div_clk[1]), 32'h0);
    steps(1); check("div3_k3", 32'(div_clk[0]), 32'h0);
    steps(1); check("div3_k4", 32'(div_clk[0]), 32'h1);
    steps(9);  // k=13, mid high phase of ch0
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 16'd1;
    check("bp_ready_k13", 32'(cfg_ready), 32'h1);
    steps(1); cfg_div = 16'd2;
    check("bp_ready_k14", 32'(cfg_ready), 32'h0);
    steps(1); check("bp_high_k15", 32'(div_clk[0]), 32'h1);
              check("bp_hold_k15", 32'(cfg_ready), 32'h0);
    steps(1); check("bp_fall_k16", 32'(div_clk[0]), 32'h0);
              check("bp_applied_k16", 32'(cfg_pending[0]), 32'h0);
    steps(1); check("bp_second_k17", 32'(cfg_pending[0]), 32'h1);
              check("div1_k17", 32'(div_clk[0]), 32'h0);
    cfg_valid = 1'b0;
    steps(1); check("div1_k18", 32'(div_clk[0]), 32'h1);
    steps(1); check("div1_k19", 32'(div_clk[0]), 32'h1);
    steps(1); check("div1_k20", 32'(div_clk[0]), 32'h0);
    steps(2); check("div2_k22", 32'(div_clk[0]), 32'h0);
    steps(1); check("div2_k23", 32'(div_clk[0]), 32'h1);

    // Enable gating on ch0 only.
    ch_en = 2'b10;
    steps(1); check("gate_off", 32'(div_clk[0]), 32'h0);
    ch_en = 2'b11;
    steps(2); check("gate_k2", 32'(div_clk[0]), 32'h0);
    steps(1); check("gate_k3", 32'(div_clk[0]), 32'h1);
              check("gate_tick", 32'(div_tick[0]), 32'h1);

    // Out-of-range channel is accepted and dropped.
    cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_div = 16'd9;
    check("oor_ready", 32'(cfg_ready), 32'h1);
    steps(1); check("oor_pend", 32'(cfg_pending), 32'h0);
    cfg_valid = 1'b0;

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) active = ~active;
      if ($urandom_range(0, 29) == 0) ch_en = NUM_CH'($urandom_range(0, 3));
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = 3'($urandom_range(0, 3));
      cfg_div   = CNT_W'($urandom_range(0, 6));
    end

    // Async reset with an update pending on ch0.
    cfg_valid = 1'b0; active = 1'b0; ch_en = 2'b11;
    steps(2);
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 16'd100;
    steps(2);
    active = 1'b1; cfg_div = 16'd50;
    steps(1); cfg_valid = 1'b0;
    steps(5); check("pre_rst_pend", 32'(cfg_pending), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_div_clk", 32'(div_clk), 32'h0);
    check("arst_tick", 32'(div_tick), 32'h0);
    check("arst_pend", 32'(cfg_pending), 32'h0);
    check("arst_ready", 32'(cfg_ready), 32'h1);
    active = 1'b0;
    steps(3);
    rst_n = 1'b1;
    default_periods("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
